instruction_fetch_rv32i: RTL and testbench
==========================================

// Module: instruction_fetch_rv32i
// PURPOSE
//  Fetch stage feeding the RV32I instruction decoder. Owns the fetch PC and issues
//  word reads to instruction memory over a req/ack handshake, at most one outstanding.
//  Queues returned words with their PC in a small FIFO and presents them to the
//  decoder over a valid/ready handshake. On a branch/jump redirect it flushes the
//  queue and restarts at the new PC.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC loaded on reset; bits [1:0] must be 0
//  FIFO_DEPTH  2              instruction queue entries; power of 2, >= 2
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  imem_req     out  1   read request; held high until imem_ack
//  imem_addr    out  32  word-aligned read address; stable while imem_req=1
//  imem_ack     in   1   request complete; imem_data valid this cycle
//  imem_data    in   32  instruction word
//  redirect     in   1   one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch PC, sampled when redirect=1
//  instr_valid  out  1   queue head valid
//  instr_ready  in   1   decoder accepts head; pop when valid && ready
//  instr        out  32  queue head instruction
//  instr_pc     out  32  PC of queue head
//  fetch_err    out  1   sticky: misaligned redirect_pc seen
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, queue empty, imem_req=0, instr_valid=0,
//   instr=0, instr_pc=0, fetch_err=0. Reset mid-request abandons it; a late ack is ignored.
//  imem_req=1 exactly in WAIT and DROP. imem_addr=pc.
//  instr_valid = (count!=0). instr/instr_pc come from FIFO registers only, with no
//   imem->instr comb path. Data reaches the decoder the cycle after ack.
//  FSM:
//   IDLE:  count<FIFO_DEPTH -> WAIT; else stay.
//   WAIT:  ack && !redirect -> push {pc,imem_data}, pc+=4;
//            next = WAIT if (count+1-pop)<FIFO_DEPTH else IDLE.
//          !ack -> stay WAIT.
//   DROP:  stale request in flight. pc already holds redirect target.
//          ack -> discard data, -> IDLE. !ack -> stay.
//   HALT:  imem_req=0, no pushes. Exit only by reset.
//  Redirect (any state except HALT):
//   - flush queue: count=0, instr_valid=0 next cycle; a same-cycle pop is void.
//   - pc=redirect_pc.
//   - state: WAIT && !ack -> DROP; WAIT && ack -> IDLE (data discarded);
//     DROP && ack -> IDLE; DROP && !ack -> stay DROP; IDLE -> IDLE.
//  Misaligned redirect (redirect_pc[1:0]!=0): flush, fetch_err=1 (sticky).
//   If a request is outstanding -> DROP and wait for its ack, then HALT; else -> HALT.
//  FIFO: count 0..FIFO_DEPTH; push and pop in the same cycle allowed, count unchanged.
//   A request is issued only with a free slot, so a push never overflows.
//   A pop on empty is ignored.
//  Throughput: 1 instr/cycle when ack is returned in the request cycle and
//   instr_ready=1. PC increments mod 2^32; 32'hFFFF_FFFC+4 wraps to 0.
// TESTING
//  1 Reset release, zero-wait mem, instr_ready=1: imem_addr 0,4,8 on consecutive
//    cycles; instr_pc 0,4,8 each one cycle after its ack; instr matches mem words.
//  2 instr_ready=0, DEPTH=2: after 2 acks imem_req=0, instr_valid=1, head pc=0.
//    instr_ready=1 for one cycle -> request at pc 8 issued next cycle.
//  3 Ack held off 3 cycles: imem_req and imem_addr=4 stable for all 3 cycles.
//    A redirect to 0x100 mid-wait -> old ack discarded (DROP), next addr=0x100,
//    no stale instr emitted.
//  4 Redirect to 0x40 in the same cycle as an ack and a pop: queue empty next cycle,
//    returned word dropped, next request addr=0x40.
//  5 Redirect to 0x42: fetch_err=1, imem_req=0 after any pending ack, stays halted
//    until rst. Assert rst while WAIT -> all outputs reset immediately.
//  6 pc=32'hFFFF_FFFC via redirect, ack -> next imem_addr=0.

Source files
------------

// File: rtl/instruction_fetch_rv32i_if.sv
// Bundles the instruction-memory bus, the redirect request and the
// decoder-facing instruction stream of the RV32I fetch stage.
interface instruction_fetch_rv32i_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_err;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    input  imem_ack, imem_data, redirect, redirect_pc, instr_ready
  );

  // Memory / branch unit / decoder side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    output imem_ack, imem_data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_rv32i.sv
// RV32I fetch stage: owns the fetch PC, issues one outstanding word read at a
// time, queues returned words with their PC and hands them to the decoder.
// Redirects flush the queue; a misaligned redirect target halts fetch until reset.
module instruction_fetch_rv32i #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  instruction_fetch_rv32i_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} state_t;

  state_t             state, state_next;
  logic               halt_pend, halt_pend_next;
  logic [31:0]        pc;
  logic               fetch_err;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [31:0]        fifo_pc    [FIFO_DEPTH];
  logic [31:0]        fifo_instr [FIFO_DEPTH];

  logic               push, pop, flush, pop_ok, redirect_act, misaligned;

  // Occupancy after applying one optional push and one optional pop.
  function automatic logic [CNT_W:0] fill_after(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    return {1'b0, cnt} + (CNT_W + 1)'(inc) - (CNT_W + 1)'(dec);
  endfunction

  assign bus.imem_req    = (state == WAIT) || (state == DROP);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = fifo_instr[rd_ptr];
  assign bus.instr_pc    = fifo_pc[rd_ptr];
  assign bus.fetch_err   = fetch_err;

  // Next-state decode, queue push/pop/flush strobes.
  always_comb begin
    state_next     = state;
    halt_pend_next = halt_pend;
    push           = 1'b0;
    flush          = 1'b0;
    pop_ok         = (count != '0) && bus.instr_ready;
    misaligned     = (bus.redirect_pc[1:0] != 2'b00);
    redirect_act   = bus.redirect && (state != HALT);
    unique case (state)
      IDLE: begin
        if (redirect_act) begin
          flush      = 1'b1;
          state_next = misaligned ? HALT : IDLE;
        end else if (fill_after(count, 1'b0, pop_ok) < DEPTH_X) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect_act) begin
          flush = 1'b1;
          if (bus.imem_ack) begin
            state_next = misaligned ? HALT : IDLE;
          end else begin
            state_next     = DROP;
            halt_pend_next = misaligned;
          end
        end else if (bus.imem_ack) begin
          push       = 1'b1;
          state_next = (fill_after(count, 1'b1, pop_ok) < DEPTH_X) ? WAIT : IDLE;
        end
      end
      DROP: begin
        if (redirect_act) begin
          flush = 1'b1;
          if (bus.imem_ack) begin
            state_next     = (halt_pend || misaligned) ? HALT : IDLE;
            halt_pend_next = 1'b0;
          end else if (misaligned) begin
            halt_pend_next = 1'b1;
          end
        end else if (bus.imem_ack) begin
          state_next     = halt_pend ? HALT : IDLE;
          halt_pend_next = 1'b0;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = IDLE;
    endcase
    pop = pop_ok && !flush;
  end

  // FSM state register and pending-halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_next;
      halt_pend <= halt_pend_next;
    end
  end

  // Fetch PC and sticky misalignment error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      fetch_err <= 1'b0;
    end else begin
      if (redirect_act) begin
        pc <= bus.redirect_pc;
      end else if (push) begin
        pc <= pc + 32'd4;
      end
      if (redirect_act && misaligned) begin
        fetch_err <= 1'b1;
      end
    end
  end

  // Instruction queue: circular buffer holding {pc, word} pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= pc;
        fifo_instr[wr_ptr] <= bus.imem_data;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_rv32i.sv
// Bench for the RV32I fetch stage: directed scenarios plus a randomized run
// against a program-order model of the instruction stream.
module tb_instruction_fetch_rv32i;
  logic clk;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  instruction_fetch_rv32i_if bus ();

  instruction_fetch_rv32i #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ack    = 1'b0;
    bus.imem_data   = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", bus.imem_req); else pass_cnt++;
    total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.instr_valid); else pass_cnt++;
    total_cnt++; if (bus.instr !== 32'h0) $display("FAIL rst_instr: got %h expected 0", bus.instr); else pass_cnt++;
    total_cnt++; if (bus.instr_pc !== 32'h0) $display("FAIL rst_pc: got %h expected 0", bus.instr_pc); else pass_cnt++;
    total_cnt++; if (bus.fetch_err !== 1'b0) $display("FAIL rst_err: got %b expected 0", bus.fetch_err); else pass_cnt++;
    total_cnt++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_addr: got %h expected 0", bus.imem_addr); else pass_cnt++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 8 && !bus.imem_req; k++) tick();
    total_cnt++; if (bus.imem_req !== 1'b1) $display("FAIL t1_req_timeout: got %b expected 1", bus.imem_req); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      e = 32'(4 * i);
      total_cnt++; if (bus.imem_addr !== e || bus.imem_req !== 1'b1) $display("FAIL t1_addr: got %h req %b expected %h", bus.imem_addr, bus.imem_req, e); else pass_cnt++;
      bus.imem_ack  = 1'b1;
      bus.imem_data = word(e);
      tick();
      total_cnt++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e) $display("FAIL t1_instr_pc: got %h valid %b expected %h", bus.instr_pc, bus.instr_valid, e); else pass_cnt++;
      total_cnt++; if (bus.instr !== word(e)) $display("FAIL t1_instr: got %h expected %h", bus.instr, word(e)); else pass_cnt++;
    end
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 8 && !bus.imem_req; k++) tick();
    bus.imem_ack = 1'b1; bus.imem_data = word(32'h0);
    tick();
    bus.imem_data = word(32'h4);
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL t2_req_full: got %b expected 0", bus.imem_req); else pass_cnt++;
    total_cnt++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) $display("FAIL t2_head: got %h valid %b expected 0", bus.instr_pc, bus.instr_valid); else pass_cnt++;
    total_cnt++; if (bus.instr !== word(32'h0)) $display("FAIL t2_head_instr: got %h expected %h", bus.instr, word(32'h0)); else pass_cnt++;
    tick();
    total_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL t2_req_hold: got %b expected 0", bus.imem_req); else pass_cnt++;
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) $display("FAIL t2_refetch: got addr %h req %b expected 8", bus.imem_addr, bus.imem_req); else pass_cnt++;
    total_cnt++; if (bus.instr_pc !== 32'h4) $display("FAIL t2_next_head: got %h expected 4", bus.instr_pc); else pass_cnt++;
  endtask

  task automatic test_wait_redirect();
    do_reset();
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 8 && !bus.imem_req; k++) tick();
    bus.imem_ack = 1'b1; bus.imem_data = word(32'h0);
    tick();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) $display("FAIL t3_stall: got addr %h req %b expected 4", bus.imem_addr, bus.imem_req); else pass_cnt++;
      tick();
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    total_cnt++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) $display("FAIL t3_drop: got req %b valid %b expected 1 0", bus.imem_req, bus.instr_valid); else pass_cnt++;
    bus.imem_ack = 1'b1; bus.imem_data = JUNK;
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) $display("FAIL t3_stale: got valid %b req %b expected 0 0", bus.instr_valid, bus.imem_req); else pass_cnt++;
    tick();
    total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) $display("FAIL t3_newaddr: got %h req %b expected 100", bus.imem_addr, bus.imem_req); else pass_cnt++;
    bus.imem_ack = 1'b1; bus.imem_data = word(32'h100);
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.instr_pc !== 32'h100 || bus.instr !== word(32'h100) || bus.instr_valid !== 1'b1) $display("FAIL t3_newinstr: got pc %h instr %h expected 100 %h", bus.instr_pc, bus.instr, word(32'h100)); else pass_cnt++;
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 8 && !bus.imem_req; k++) tick();
    bus.imem_ack = 1'b1; bus.imem_data = word(32'h0);
    tick();
    bus.imem_data = word(32'h4);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    tick();
    bus.imem_ack = 1'b0; bus.redirect = 1'b0;
    total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL t4_flush: got %b expected 0", bus.instr_valid); else pass_cnt++;
    tick();
    total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) $display("FAIL t4_addr: got %h req %b expected 40", bus.imem_addr, bus.imem_req); else pass_cnt++;
    bus.imem_ack = 1'b1; bus.imem_data = word(32'h40);
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.instr_pc !== 32'h40 || bus.instr_valid !== 1'b1) $display("FAIL t4_instr: got pc %h valid %b expected 40", bus.instr_pc, bus.instr_valid); else pass_cnt++;
  endtask

  task automatic test_misaligned_halt();
    do_reset();
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 8 && !bus.imem_req; k++) tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h42;
    tick();
    bus.redirect = 1'b0;
    total_cnt++; if (bus.fetch_err !== 1'b1) $display("FAIL t5_err: got %b expected 1", bus.fetch_err); else pass_cnt++;
    total_cnt++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) $display("FAIL t5_pending: got req %b valid %b expected 1 0", bus.imem_req, bus.instr_valid); else pass_cnt++;
    bus.imem_ack = 1'b1; bus.imem_data = JUNK;
    tick();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_err !== 1'b1) $display("FAIL t5_halt: got req %b valid %b err %b expected 0 0 1", bus.imem_req, bus.instr_valid, bus.fetch_err); else pass_cnt++;
      bus.redirect    = (i == 1);
      bus.redirect_pc = 32'h80;
      bus.imem_ack    = (i == 2);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8 && !bus.imem_req; k++) tick();
    bus.imem_ack = 1'b1; bus.imem_data = word(32'h0);
    tick();
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_err !== 1'b0) $display("FAIL t5_async_ctl: got req %b valid %b err %b expected 0 0 0", bus.imem_req, bus.instr_valid, bus.fetch_err); else pass_cnt++;
    total_cnt++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.imem_addr !== 32'h0) $display("FAIL t5_async_data: got instr %h pc %h addr %h expected 0", bus.instr, bus.instr_pc, bus.imem_addr); else pass_cnt++;
    bus.imem_ack = 1'b1; bus.imem_data = JUNK;
    tick();
    rst = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL t5_late_ack: got %b expected 0", bus.instr_valid); else pass_cnt++;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 8 && !bus.imem_req; k++) tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_data = JUNK;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL t6_top: got %h req %b expected fffffffc", bus.imem_addr, bus.imem_req); else pass_cnt++;
    bus.imem_ack = 1'b1; bus.imem_data = word(32'hFFFF_FFFC);
    tick();
    bus.imem_ack = 1'b0;
    total_cnt++; if (bus.imem_addr !== 32'h0) $display("FAIL t6_wrap: got %h expected 0", bus.imem_addr); else pass_cnt++;
    total_cnt++; if (bus.instr_pc !== 32'hFFFF_FFFC || bus.instr !== word(32'hFFFF_FFFC)) $display("FAIL t6_instr: got pc %h instr %h expected fffffffc", bus.instr_pc, bus.instr); else pass_cnt++;
  endtask

  // Program-order model: the decoder must see consecutive word PCs starting at
  // the last redirect target, each carrying that address's memory word.
  task automatic test_random();
    logic [31:0] exp_pc, prev_addr, rpc;
    logic        stale, prev_hold, prev_redir, ack, redir, rdy;
    int          delivered;
    do_reset();
    exp_pc = 32'h0; stale = 1'b0; prev_hold = 1'b0; prev_redir = 1'b0;
    prev_addr = 32'h0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_hold) begin
        total_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) $display("FAIL rnd_hold: got addr %h req %b expected %h", bus.imem_addr, bus.imem_req, prev_addr); else pass_cnt++;
      end
      if (prev_redir) begin
        total_cnt++; if (bus.instr_valid !== 1'b0) $display("FAIL rnd_flush: got %b expected 0", bus.instr_valid); else pass_cnt++;
      end
      ack   = bus.imem_req && ($urandom_range(2) != 0);
      rdy   = ($urandom_range(3) != 0);
      redir = ($urandom_range(29) == 0);
      rpc   = 32'($urandom_range(1023)) << 2;
      bus.imem_ack    = ack;
      bus.imem_data   = stale ? JUNK : word(bus.imem_addr);
      bus.instr_ready = rdy;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      if (bus.instr_valid && rdy && !redir) begin
        total_cnt++; if (bus.instr_pc !== exp_pc || bus.instr !== word(exp_pc)) $display("FAIL rnd_instr: got pc %h instr %h expected %h %h", bus.instr_pc, bus.instr, exp_pc, word(exp_pc)); else pass_cnt++;
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (ack) stale = 1'b0;
      if (redir) begin
        exp_pc = rpc;
        if (bus.imem_req && !ack) stale = 1'b1;
      end
      prev_hold  = bus.imem_req && !ack && !redir;
      prev_addr  = bus.imem_addr;
      prev_redir = redir;
      tick();
    end
    idle_inputs();
    total_cnt++; if (delivered < 200) $display("FAIL rnd_progress: got %0d delivered expected >= 200", delivered); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_redirect();
    test_redirect_ack_pop();
    test_misaligned_halt();
    test_pc_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
